// File: rtl/sipo_load_arbiter.sv
// Round-robin arbiter that serializes a granted parallel word MSB-first onto a SIPO shift register.
// Optional SIPO_FRAME_CNT_EN adds an 8-bit FRAME_CNT output counting completed frames.
module sipo_load_arbiter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned IDLE_GAP = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ0,
    input  logic [WIDTH-1:0] DATA0,
    output logic             ACK0,
    input  logic             REQ1,
    input  logic [WIDTH-1:0] DATA1,
    output logic             ACK1,
    output logic             SDO,
    output logic             SR_VALID,
    output logic             GNT_ID,
`ifdef SIPO_FRAME_CNT_EN
    output logic [7:0]       FRAME_CNT,
`endif
    output logic             BUSY
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]       state,    state_nxt;
    logic [WIDTH-1:0] hold,     hold_nxt;
    logic [CW-1:0]    bit_cnt,  bit_cnt_nxt;
    logic [GW-1:0]    gap_cnt,  gap_cnt_nxt;
    logic             prio,     prio_nxt;
    logic             ack0_nxt, ack1_nxt, sdo_nxt, sr_valid_nxt, gnt_id_nxt, busy_nxt;

    logic             req_any;
    logic             pick;
    logic [WIDTH-1:0] grant_word;
    logic             idle_eval;

    // Arbitration: a lone requester wins; on a tie the favoured one (not granted last) wins.
    always_comb begin
        req_any    = REQ0 | REQ1;
        pick       = (REQ0 & REQ1) ? prio : REQ1;
        grant_word = pick ? DATA1 : DATA0;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt    = state;
        hold_nxt     = hold;
        bit_cnt_nxt  = bit_cnt;
        gap_cnt_nxt  = gap_cnt;
        prio_nxt     = prio;
        ack0_nxt     = 1'b0;
        ack1_nxt     = 1'b0;
        sdo_nxt      = SDO;
        sr_valid_nxt = 1'b0;
        gnt_id_nxt   = GNT_ID;
        busy_nxt     = BUSY;
        idle_eval    = 1'b0;

        case (state)
            S_IDLE: begin
                idle_eval = 1'b1;
            end
            S_SHIFT: begin
                if (bit_cnt != '0) begin
                    sdo_nxt     = hold[bit_cnt - CW'(1)];
                    bit_cnt_nxt = bit_cnt - CW'(1);
                end else begin
                    // Last bit has just been captured downstream: word is complete.
                    sr_valid_nxt = 1'b1;
                    if (IDLE_GAP == 0) begin
                        idle_eval = 1'b1;
                    end else begin
                        sdo_nxt     = 1'b0;
                        gap_cnt_nxt = GW'(IDLE_GAP - 1);
                        state_nxt   = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == '0) begin
                    idle_eval = 1'b1;
                end else begin
                    gap_cnt_nxt = gap_cnt - GW'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                sdo_nxt   = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase

        // The last gap edge doubles as the first IDLE edge so the frame period is WIDTH+IDLE_GAP.
        if (idle_eval) begin
            if (req_any) begin
                hold_nxt    = grant_word;
                ack0_nxt    = ~pick;
                ack1_nxt    = pick;
                gnt_id_nxt  = pick;
                prio_nxt    = ~pick;
                busy_nxt    = 1'b1;
                sdo_nxt     = grant_word[WIDTH-1];
                bit_cnt_nxt = CW'(WIDTH - 1);
                state_nxt   = S_SHIFT;
            end else begin
                sdo_nxt   = 1'b0;
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
        end
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= S_IDLE;
            hold     <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            prio     <= 1'b0;
            ACK0     <= 1'b0;
            ACK1     <= 1'b0;
            SDO      <= 1'b0;
            SR_VALID <= 1'b0;
            GNT_ID   <= 1'b0;
            BUSY     <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold     <= hold_nxt;
            bit_cnt  <= bit_cnt_nxt;
            gap_cnt  <= gap_cnt_nxt;
            prio     <= prio_nxt;
            ACK0     <= ack0_nxt;
            ACK1     <= ack1_nxt;
            SDO      <= sdo_nxt;
            SR_VALID <= sr_valid_nxt;
            GNT_ID   <= gnt_id_nxt;
            BUSY     <= busy_nxt;
        end
    end

`ifdef SIPO_FRAME_CNT_EN
    // Completed-frame counter, advances together with SR_VALID and wraps naturally.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            FRAME_CNT <= 8'd0;
        end else if (sr_valid_nxt) begin
            FRAME_CNT <= FRAME_CNT + 8'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    // Sanity properties on the registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            assert (!(ACK0 && ACK1)) else $error("both acknowledges asserted");
            assert (!(ACK0 || ACK1) || BUSY) else $error("acknowledge without busy");
        end
    end
`endif

endmodule

// File: tb/tb_sipo_load_arbiter.sv
// Directed, table-driven bench for sipo_load_arbiter with a behavioural model of the downstream shift register.
module tb_sipo_load_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: IDLE_GAP = 1
    logic       rst, req0, req1;
    logic [3:0] d0, d1;
    logic       ack0_a, ack1_a, sdo_a, srv_a, gnt_a, busy_a;
    logic [3:0] qa;
    // DUT B: IDLE_GAP = 0
    logic       rst_b, req0_b, req1_b;
    logic [3:0] d0_b, d1_b;
    logic       ack0_b, ack1_b, sdo_b, srv_b, gnt_b, busy_b;
    logic [3:0] qb;
`ifdef SIPO_FRAME_CNT_EN
    logic [7:0] fc_a, fc_b;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    sipo_load_arbiter #(.WIDTH(4), .IDLE_GAP(1)) dut_a (
        .CLK(clk), .RST(rst),
        .REQ0(req0), .DATA0(d0), .ACK0(ack0_a),
        .REQ1(req1), .DATA1(d1), .ACK1(ack1_a),
        .SDO(sdo_a), .SR_VALID(srv_a), .GNT_ID(gnt_a),
`ifdef SIPO_FRAME_CNT_EN
        .FRAME_CNT(fc_a),
`endif
        .BUSY(busy_a)
    );

    sipo_load_arbiter #(.WIDTH(4), .IDLE_GAP(0)) dut_b (
        .CLK(clk), .RST(rst_b),
        .REQ0(req0_b), .DATA0(d0_b), .ACK0(ack0_b),
        .REQ1(req1_b), .DATA1(d1_b), .ACK1(ack1_b),
        .SDO(sdo_b), .SR_VALID(srv_b), .GNT_ID(gnt_b),
`ifdef SIPO_FRAME_CNT_EN
        .FRAME_CNT(fc_b),
`endif
        .BUSY(busy_b)
    );

    // Downstream shift registers (no reset in hardware; cleared here for predictability).
    always @(posedge clk) begin
        if (!rst) qa <= 4'd0; else qa <= {qa[2:0], sdo_a};
        if (!rst_b) qb <= 4'd0; else qb <= {qb[2:0], sdo_b};
    end

    typedef struct {
        logic       rst, req0;
        logic [3:0] d0;
        logic       req1;
        logic [3:0] d1;
        logic       ack0, ack1, sdo, srv, gnt, busy;
        logic       cq;
        logic [3:0] q;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic r0, input logic [3:0] x0,
                       input logic r1, input logic [3:0] x1,
                       input logic a0, input logic a1, input logic s, input logic v,
                       input logic g, input logic b, input logic cq, input logic [3:0] q);
        vec_t e;
        e.rst = r; e.req0 = r0; e.d0 = x0; e.req1 = r1; e.d1 = x1;
        e.ack0 = a0; e.ack1 = a1; e.sdo = s; e.srv = v; e.gnt = g; e.busy = b;
        e.cq = cq; e.q = q;
        vecs.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic a0, input logic a1, input logic s,
                         input logic v, input logic g, input logic b);
        chk({tag, ".ack0"}, 32'(ack0_a), 32'(a0));
        chk({tag, ".ack1"}, 32'(ack1_a), 32'(a1));
        chk({tag, ".sdo"},  32'(sdo_a),  32'(s));
        chk({tag, ".srv"},  32'(srv_a),  32'(v));
        chk({tag, ".gnt"},  32'(gnt_a),  32'(g));
        chk({tag, ".busy"}, 32'(busy_a), 32'(b));
    endtask

    task automatic chk_b(input string tag, input logic a0, input logic a1, input logic s,
                         input logic v, input logic g, input logic b);
        chk({tag, ".ack0"}, 32'(ack0_b), 32'(a0));
        chk({tag, ".ack1"}, 32'(ack1_b), 32'(a1));
        chk({tag, ".sdo"},  32'(sdo_b),  32'(s));
        chk({tag, ".srv"},  32'(srv_b),  32'(v));
        chk({tag, ".gnt"},  32'(gnt_b),  32'(g));
        chk({tag, ".busy"}, 32'(busy_b), 32'(b));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] word;
        logic       id;

        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; d0 = 4'd0; d1 = 4'd0;
        rst_b = 1'b0; req0_b = 1'b0; req1_b = 1'b0; d0_b = 4'd0; d1_b = 4'd0;

        //  rst r0 d0    r1 d1   | a0 a1 sdo srv gnt busy | cq q
        // Reset, then single frame of 1011 from requester 0; DATA0 changes after ACK.
        add(0, 0, 4'h0, 0, 4'h0,  0, 0, 0, 0, 0, 0,  0, 4'h0);
        add(0, 0, 4'h0, 0, 4'h0,  0, 0, 0, 0, 0, 0,  0, 4'h0);
        add(1, 1, 4'hB, 0, 4'h0,  1, 0, 1, 0, 0, 1,  0, 4'h0);
        add(1, 0, 4'h0, 0, 4'h0,  0, 0, 0, 0, 0, 1,  1, 4'h1);
        add(1, 0, 4'h0, 0, 4'h0,  0, 0, 1, 0, 0, 1,  1, 4'h2);
        add(1, 0, 4'h0, 0, 4'h0,  0, 0, 1, 0, 0, 1,  1, 4'h5);
        add(1, 0, 4'h0, 0, 4'h0,  0, 0, 0, 1, 0, 1,  1, 4'hB);
        add(1, 0, 4'h0, 0, 4'h0,  0, 0, 0, 0, 0, 0,  0, 4'h0);
        add(1, 0, 4'h0, 0, 4'h0,  0, 0, 0, 0, 0, 0,  0, 4'h0);
        // Grant 4'hF then reset two edges later: frame abandoned, REQ1 alone wins afterwards.
        add(1, 1, 4'hF, 0, 4'h0,  1, 0, 1, 0, 0, 1,  0, 4'h0);
        add(1, 0, 4'hF, 0, 4'h0,  0, 0, 1, 0, 0, 1,  0, 4'h0);
        add(0, 0, 4'hF, 0, 4'h0,  0, 0, 0, 0, 0, 0,  0, 4'h0);
        add(1, 0, 4'h0, 0, 4'h0,  0, 0, 0, 0, 0, 0,  0, 4'h0);
        add(1, 0, 4'h0, 0, 4'h0,  0, 0, 0, 0, 0, 0,  0, 4'h0);
        add(1, 0, 4'h0, 0, 4'h0,  0, 0, 0, 0, 0, 0,  0, 4'h0);
        add(1, 0, 4'h0, 1, 4'hA,  0, 1, 1, 0, 1, 1,  0, 4'h0);
        add(1, 0, 4'h0, 0, 4'h0,  0, 0, 0, 0, 1, 1,  0, 4'h0);
        add(1, 0, 4'h0, 0, 4'h0,  0, 0, 1, 0, 1, 1,  0, 4'h0);
        add(1, 0, 4'h0, 0, 4'h0,  0, 0, 0, 0, 1, 1,  0, 4'h0);
        add(1, 0, 4'h0, 0, 4'h0,  0, 0, 0, 1, 1, 1,  1, 4'hA);
        add(1, 0, 4'h0, 0, 4'h0,  0, 0, 0, 0, 1, 0,  0, 4'h0);
        // REQ1 pulsed for one cycle while requester 0 frame is busy: ignored.
        add(1, 1, 4'h5, 0, 4'h0,  1, 0, 0, 0, 0, 1,  0, 4'h0);
        add(1, 0, 4'h0, 1, 4'hE,  0, 0, 1, 0, 0, 1,  0, 4'h0);
        add(1, 0, 4'h0, 0, 4'h0,  0, 0, 0, 0, 0, 1,  0, 4'h0);
        add(1, 0, 4'h0, 0, 4'h0,  0, 0, 1, 0, 0, 1,  0, 4'h0);
        add(1, 0, 4'h0, 0, 4'h0,  0, 0, 0, 1, 0, 1,  1, 4'h5);
        add(1, 0, 4'h0, 0, 4'h0,  0, 0, 0, 0, 0, 0,  0, 4'h0);
        add(1, 0, 4'h0, 0, 4'h0,  0, 0, 0, 0, 0, 0,  0, 4'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; req0 = vecs[i].req0; d0 = vecs[i].d0;
            req1 = vecs[i].req1; d1 = vecs[i].d1;
            step();
            chk_a($sformatf("vec%0d", i), vecs[i].ack0, vecs[i].ack1, vecs[i].sdo,
                  vecs[i].srv, vecs[i].gnt, vecs[i].busy);
            if (vecs[i].cq) chk($sformatf("vec%0d.q", i), 32'(qa), 32'(vecs[i].q));
        end

        // Both requesters held: grants alternate 0,1,0,1 with a 5-cycle period.
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        step();
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; d0 = 4'h3; d1 = 4'hC;
        for (int f = 0; f < 4; f++) begin
            id   = f[0];
            word = id ? 4'hC : 4'h3;
            for (int e = 0; e < 5; e++) begin
                step();
                if (e == 0)
                    chk_a($sformatf("alt%0d.e%0d", f, e), ~id, id, word[3], 1'b0, id, 1'b1);
                else if (e < 4)
                    chk_a($sformatf("alt%0d.e%0d", f, e), 1'b0, 1'b0, word[3-e], 1'b0, id, 1'b1);
                else begin
                    chk_a($sformatf("alt%0d.e%0d", f, e), 1'b0, 1'b0, 1'b0, 1'b1, id, 1'b1);
                    chk($sformatf("alt%0d.q", f), 32'(qa), 32'(word));
                end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
        chk_a("alt_end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // IDLE_GAP=0: back-to-back frames of 4'h9 from requester 1.
        step();
        chk_b("b_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_b = 1'b1; req1_b = 1'b1; d1_b = 4'h9;
        step();
        chk_b("b_e0", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        word = 4'h9;
        for (int f = 0; f < 3; f++) begin
            for (int e = 1; e <= 4; e++) begin
                step();
                if (e < 4)
                    chk_b($sformatf("b%0d.e%0d", f, e), 1'b0, 1'b0, word[3-e], 1'b0, 1'b1, 1'b1);
                else begin
                    chk_b($sformatf("b%0d.e%0d", f, e), 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
                    chk($sformatf("b%0d.q", f), 32'(qb), 32'(word));
                end
            end
        end
        req1_b = 1'b0;

`ifdef SIPO_FRAME_CNT_EN
        // 257 frames: the counter wraps through 0 and reads 1.
        begin
            int pulses;
            pulses = 0;
            rst = 1'b0;
            step();
            chk("fc_reset", 32'(fc_a), 32'd0);
            rst = 1'b1; req0 = 1'b1; d0 = 4'h6;
            for (int c = 0; c < 3000 && pulses < 257; c++) begin
                step();
                if (srv_a) pulses++;
            end
            chk("fc_pulses", 32'(pulses), 32'd257);
            chk("fc_wrap", 32'(fc_a), 32'd1);
            req0 = 1'b0;
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
